// File: rtl/grp_seq.sv
// ============================================================================
// Module   : grp_seq
// Purpose  : Register-group load/store sequencer; one memory word per register
//            over a req/ack handshake, with register-file select/write strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module grp_seq (
   input  logic        clk_,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  grp,
   input  logic        dir,
   input  logic [15:0] base_addr,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [2:0]  reg_sel,
   input  logic [15:0] reg_rdata,
   output logic        reg_we,
   output logic [15:0] reg_wdata
);

   localparam logic [1:0] C_ST_IDLE = 2'd0;
   localparam logic [1:0] C_ST_REQ  = 2'd1;
   localparam logic [1:0] C_ST_WB   = 2'd2;
   localparam logic [1:0] C_ST_DONE = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_dir;
   logic [15:0] r_addr;
   logic [2:0]  r_sel;
   logic [2:0]  r_cnt;
   logic [15:0] r_wdata;
   logic        w_last;
   logic        w_advance;

   assign w_last = (r_cnt == 3'd0);

   // Step to the next word: after a store ack, or at the end of a load write-back
   assign w_advance = !abort && !w_last &&
                      (((r_state == C_ST_REQ) && mem_ack && r_dir) ||
                       (r_state == C_ST_WB));

   always_ff @(posedge clk_) begin
      if (reset) begin
         r_state <= C_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_IDLE: begin
            if (start) begin
               w_state_nxt = C_ST_REQ;
            end
         end
         C_ST_REQ: begin
            if (abort) begin
               w_state_nxt = C_ST_IDLE;
            end else if (mem_ack) begin
               if (!r_dir) begin
                  w_state_nxt = C_ST_WB;
               end else if (w_last) begin
                  w_state_nxt = C_ST_DONE;
               end else begin
                  w_state_nxt = C_ST_REQ;
               end
            end
         end
         C_ST_WB: begin
            if (abort) begin
               w_state_nxt = C_ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = C_ST_DONE;
            end else begin
               w_state_nxt = C_ST_REQ;
            end
         end
         default: begin
            w_state_nxt = C_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_) begin
      if (reset) begin
         r_dir   <= 1'b0;
         r_addr  <= 16'h0000;
         r_sel   <= 3'd0;
         r_cnt   <= 3'd0;
         r_wdata <= 16'h0000;
      end else begin
         if ((r_state == C_ST_IDLE) && start) begin
            r_dir  <= dir;
            r_addr <= base_addr;
            r_sel  <= (grp == 2'd3) ? 3'd5 : 3'd1;
            case (grp)
               2'd0:    r_cnt <= 3'd1;
               2'd1:    r_cnt <= 3'd2;
               2'd2:    r_cnt <= 3'd6;
               default: r_cnt <= 3'd2;
            endcase
         end else if (w_advance) begin
            r_addr <= r_addr + 16'd1;
            r_sel  <= r_sel + 3'd1;
            r_cnt  <= r_cnt - 3'd1;
         end
         if ((r_state == C_ST_REQ) && mem_ack && !abort && !r_dir) begin
            r_wdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      busy      = (r_state != C_ST_IDLE);
      done      = (r_state == C_ST_DONE);
      mem_req   = (r_state == C_ST_REQ);
      reg_we    = (r_state == C_ST_WB);
      mem_we    = r_dir;
      mem_addr  = r_addr;
      reg_sel   = r_sel;
      reg_wdata = r_wdata;
      mem_wdata = (r_state == C_ST_REQ) ? reg_rdata : 16'h0000;
   end

endmodule

`default_nettype wire

// File: tb/tb_grp_seq.sv
// ============================================================================
// Module   : tb_grp_seq
// Purpose  : Self-checking bench for grp_seq against a transfer-list model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_grp_seq;

   logic        clk_ = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  grp = 2'd0;
   logic        dir = 1'b0;
   logic [15:0] base_addr = 16'h0000;
   logic        abort = 1'b0;
   logic        busy, done, mem_req, mem_we, reg_we;
   logic [15:0] mem_addr, mem_wdata, reg_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic [2:0]  reg_sel;
   logic [15:0] reg_rdata;

   logic [15:0] regs [8];
   logic [15:0] rdq [$];
   int          checks = 0;
   int          errors = 0;

   assign reg_rdata = regs[reg_sel];

   always #5 clk_ = ~clk_;

   grp_seq dut (
      .clk_      (clk_),
      .reset     (reset),
      .start     (start),
      .grp       (grp),
      .dir       (dir),
      .base_addr (base_addr),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .reg_sel   (reg_sel),
      .reg_rdata (reg_rdata),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_req", 16'(mem_req), 16'd0);
      chk("rst_we", 16'(mem_we), 16'd0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_sel", 16'(reg_sel), 16'd0);
      chk("rst_regwe", 16'(reg_we), 16'd0);
      chk("rst_wdata", reg_wdata, 16'h0000);
   endtask

   // One group transfer driven cycle by cycle from negedge to negedge.
   // abort_word: abort on that word's ack; restart_cyc: extra start pulse;
   // reset_word: reset (with start and abort) in that word's first REQ cycle.
   task automatic run(input logic [1:0] g, input logic d, input logic [15:0] base,
                      input int wt, input int abort_word, input int restart_cyc,
                      input int reset_word);
      int          len, first, exp_done, k, word, wc;
      logic        pend, fin, rst_case;
      logic [15:0] pend_data, data;
      case (g)
         2'd0:    begin len = 2; first = 1; end
         2'd1:    begin len = 3; first = 1; end
         2'd2:    begin len = 7; first = 1; end
         default: begin len = 3; first = 5; end
      endcase
      exp_done = d ? len * (1 + wt) + 1 : len * (2 + wt) + 1;
      start = 1'b1; grp = g; dir = d; base_addr = base;
      @(negedge clk_);
      grp = 2'($urandom); dir = 1'($urandom); base_addr = 16'($urandom);
      k = 1; word = 0; wc = 0; pend = 1'b0; fin = 1'b0; rst_case = 1'b0;
      pend_data = 16'h0000;
      while (!fin) begin
         mem_ack = 1'b0; abort = 1'b0;
         start = (k == restart_cyc);
         if (word == len && !pend) begin
            chk("done", 16'(done), 16'd1);
            chk("done_busy", 16'(busy), 16'd1);
            chk("done_req", 16'(mem_req), 16'd0);
            chk("done_lat", 16'(k), 16'(exp_done));
            fin = 1'b1;
         end else if (pend) begin
            chk("wb_regwe", 16'(reg_we), 16'd1);
            chk("wb_req", 16'(mem_req), 16'd0);
            chk("wb_sel", 16'(reg_sel), 16'(first + word - 1));
            chk("wb_data", reg_wdata, pend_data);
            regs[first + word - 1] = pend_data;
            pend = 1'b0;
         end else begin
            chk("req", 16'(mem_req), 16'd1);
            chk("req_busy", 16'(busy), 16'd1);
            chk("req_regwe", 16'(reg_we), 16'd0);
            chk("req_done", 16'(done), 16'd0);
            chk("req_addr", mem_addr, base + 16'(word));
            chk("req_sel", 16'(reg_sel), 16'(first + word));
            chk("req_memwe", 16'(mem_we), 16'(d));
            if (d) chk("req_wdata", mem_wdata, regs[first + word]);
            if (word == reset_word && wc == 0) begin
               reset = 1'b1; start = 1'b1; abort = 1'b1;
               rst_case = 1'b1; fin = 1'b1;
            end else if (wc == wt) begin
               data = (rdq.size() > 0) ? rdq.pop_front() : 16'($urandom);
               mem_ack = 1'b1; mem_rdata = data;
               if (word == abort_word) begin
                  abort = 1'b1; fin = 1'b1;
               end else if (!d) begin
                  pend = 1'b1; pend_data = data;
               end
               word++; wc = 0;
            end else begin
               wc++;
            end
         end
         @(negedge clk_);
         k++;
      end
      mem_ack = 1'b0; abort = 1'b0; start = 1'b0;
      if (rst_case) begin
         chk_reset_outputs();
         reset = 1'b0;
         @(negedge clk_);
         chk("post_rst_busy", 16'(busy), 16'd0);
      end else begin
         chk("post_busy", 16'(busy), 16'd0);
         chk("post_done", 16'(done), 16'd0);
         chk("post_regwe", 16'(reg_we), 16'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      repeat (2) @(negedge clk_);
      chk_reset_outputs();
      reset = 1'b0;
      @(negedge clk_);
      chk("idle_busy", 16'(busy), 16'd0);

      // load R1..R2 from 0100, zero-wait
      rdq.push_back(16'h1111);
      rdq.push_back(16'h2222);
      run(2'd0, 1'b0, 16'h0100, 0, -1, -1, -1);
      chk("r1_loaded", regs[1], 16'h1111);
      chk("r2_loaded", regs[2], 16'h2222);

      // store R5..R7 across the address wrap, back-to-back start
      regs[5] = 16'hAAAA; regs[6] = 16'hBBBB; regs[7] = 16'hCCCC;
      run(2'd3, 1'b1, 16'hFFFE, 0, -1, -1, -1);

      // load R1..R7 with three wait states per word
      run(2'd2, 1'b0, 16'($urandom), 3, -1, -1, -1);

      // load R1..R3 aborted on the second ack
      run(2'd1, 1'b0, 16'($urandom), 0, 1, -1, -1);

      // store with a second start mid-transfer, then reset during a REQ
      run(2'd2, 1'b1, 16'($urandom), 1, -1, 2, 3);

      for (int r = 0; r < 10; r++) begin
         run(2'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1,
             int'($urandom_range(2, 4)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
